// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : DEPTH-entry FIFO of decoded instructions between decode and
//               execute, with valid/ready handshakes on both sides,
//               synchronous flush, and a combinational lookup of pending
//               register writes for the decoder's source operands.
//
// Ports       :
//   clk, rst_n            clock (rising edge) / async active-low reset
//   flush_in              kill all queued entries and this cycle's enqueue
//   in_valid / in_ready   enqueue handshake (in_ready = count < DEPTH)
//   in_pc, in_payload,
//   in_rd, in_rd_write,
//   in_bp_taken           fields of the offered entry
//   out_valid / out_ready dequeue handshake (out_valid = count != 0)
//   out_pc, out_payload,
//   out_rd, out_rd_write,
//   out_bp_taken          fields of the head entry
//   query_rs1/2           source registers to check for pending writes
//   hazard_rs1/2_out      a queued entry will write that register
//   count_out             occupancy
//   full_out, empty_out   count == DEPTH / count == 0
//
// Revision    : 1.0  initial release
// ============================================================================
module decode_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 160,
  parameter int PC_W      = 64,
  parameter int REG_W     = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [REG_W-1:0]             in_rd,
  input  logic                         in_rd_write,
  input  logic                         in_bp_taken,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [REG_W-1:0]             out_rd,
  output logic                         out_rd_write,
  output logic                         out_bp_taken,
  input  logic [REG_W-1:0]             query_rs1,
  input  logic [REG_W-1:0]             query_rs2,
  output logic                         hazard_rs1_out,
  output logic                         hazard_rs2_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         full_out,
  output logic                         empty_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage: not reset; only slot_valid qualifies its contents.
  logic [PC_W-1:0]      pc_mem      [DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic [REG_W-1:0]     rd_mem      [DEPTH];
  logic [DEPTH-1:0]     rd_write_mem;
  logic [DEPTH-1:0]     bp_mem;

  logic [DEPTH-1:0]     slot_valid;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic                 enq;
  logic                 deq;
  logic [DEPTH-1:0]     match_rs1;
  logic [DEPTH-1:0]     match_rs2;

  // Handshake status comes only from registered count, so there is no
  // combinational path from in_valid/out_ready to in_ready/out_valid.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign full_out  = (count == FULL_CNT);
  assign empty_out = (count == '0);
  assign count_out = count;

  assign enq = in_valid  & in_ready  & ~flush_in;
  assign deq = out_valid & out_ready & ~flush_in;

  // Control state: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else if (flush_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      // head == tail with both enq and deq cannot occur: that pointer
      // equality means empty (no deq) or full (no enq).
      if (enq) begin
        tail             <= tail + PTR_W'(1);
        slot_valid[tail] <= 1'b1;
      end
      if (deq) begin
        head             <= head + PTR_W'(1);
        slot_valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry data written at tail on accepted enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]       <= in_pc;
      payload_mem[tail]  <= in_payload;
      rd_mem[tail]       <= in_rd;
      rd_write_mem[tail] <= in_rd_write;
      bp_mem[tail]       <= in_bp_taken;
    end
  end

  // Head entry presented straight from storage (no fall-through path).
  assign out_pc       = pc_mem[head];
  assign out_payload  = payload_mem[head];
  assign out_rd       = rd_mem[head];
  assign out_rd_write = rd_write_mem[head];
  assign out_bp_taken = bp_mem[head];

  // Pending-write lookup over stored slots only; an entry leaving this
  // cycle is still counted because its valid bit clears at the edge.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot_match
    assign match_rs1[i] = slot_valid[i] & rd_write_mem[i] & (rd_mem[i] == query_rs1);
    assign match_rs2[i] = slot_valid[i] & rd_write_mem[i] & (rd_mem[i] == query_rs2);
  end

  // Register 0 is hardwired, so it never carries a hazard.
  assign hazard_rs1_out = (query_rs1 != '0) & (|match_rs1);
  assign hazard_rs2_out = (query_rs2 != '0) & (|match_rs2);

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_queue
// Description : Scoreboard testbench for decode_queue (default parameters).
// Revision    : 1.0  initial release
// ============================================================================
module tb_decode_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_in;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_pc;
  logic [159:0] in_payload;
  logic [8:0]   in_rd;
  logic         in_rd_write;
  logic         in_bp_taken;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_pc;
  logic [159:0] out_payload;
  logic [8:0]   out_rd;
  logic         out_rd_write;
  logic         out_bp_taken;
  logic [8:0]   query_rs1;
  logic [8:0]   query_rs2;
  logic         hazard_rs1_out;
  logic         hazard_rs2_out;
  logic [2:0]   count_out;
  logic         full_out;
  logic         empty_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0]  pc;
    logic [159:0] payload;
    logic [8:0]   rd;
    logic         rdw;
    logic         bp;
  } ent_t;

  ent_t sb[$];

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_payload(in_payload), .in_rd(in_rd), .in_rd_write(in_rd_write),
    .in_bp_taken(in_bp_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_payload(out_payload), .out_rd(out_rd),
    .out_rd_write(out_rd_write), .out_bp_taken(out_bp_taken),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .hazard_rs1_out(hazard_rs1_out), .hazard_rs2_out(hazard_rs2_out),
    .count_out(count_out), .full_out(full_out), .empty_out(empty_out)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] mk_pay(input logic [63:0] pc);
    logic [31:0] mid;
    mid = 32'hC0DE_0000 | {16'h0, pc[15:0]};
    return {pc ^ 64'hDEAD_BEEF_0123_4567, mid, pc};
  endfunction

  function automatic logic exp_haz(input logic [8:0] q);
    logic h;
    h = 1'b0;
    foreach (sb[i]) if (sb[i].rdw && sb[i].rd == q) h = 1'b1;
    return h && (q != 9'd0);
  endfunction

  // Stimulus helpers only: drive inputs / advance time.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [63:0] pc, input logic [8:0] rd,
                        input logic rdw, input logic bp);
    in_pc       = pc;
    in_payload  = mk_pay(pc);
    in_rd       = rd;
    in_rd_write = rdw;
    in_bp_taken = bp;
  endtask

  task automatic push_in();
    ent_t e;
    e.pc = in_pc; e.payload = in_payload; e.rd = in_rd;
    e.rdw = in_rd_write; e.bp = in_bp_taken;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(64'h0, 9'd0, 1'b0, 1'b0);
    query_rs1 = 9'd5; query_rs2 = 9'd7;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (empty_out !== 1'b1 || full_out !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty_out, full_out); end
    vectors++; if (count_out !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    vectors++; if (hazard_rs1_out !== 1'b0 || hazard_rs2_out !== 1'b0) begin miscompares++; $display("FAIL reset_hazard: got %b%b expected 00", hazard_rs1_out, hazard_rs2_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      set_in(64'h100 + 64'(4 * k), 9'(k + 1), 1'b1, k[0]);
      vectors++; if (count_out !== 3'(k)) begin miscompares++; $display("FAIL fill_count: got %0d expected %0d", count_out, k); end
      push_in();
      tick();
    end
    vectors++; if (count_out !== 3'd4) begin miscompares++; $display("FAIL fill_count4: got %0d expected 4", count_out); end
    vectors++; if (in_ready !== 1'b0 || full_out !== 1'b1) begin miscompares++; $display("FAIL fill_full: got ready=%b full=%b expected 0/1", in_ready, full_out); end
    set_in(64'h110, 9'd9, 1'b1, 1'b0);
    tick();
    vectors++; if (count_out !== 3'd4) begin miscompares++; $display("FAIL fill_reject: got count %0d expected 4", count_out); end
    vectors++; if (out_pc !== 64'h100) begin miscompares++; $display("FAIL fill_head_stable: got %0h expected 100", out_pc); end
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    logic enq;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_in(64'h110, 9'd9, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sb.size() == 0 && !in_valid) break;
      vectors++; if (in_ready !== (sb.size() < 4)) begin miscompares++; $display("FAIL b2b_in_ready: got %b expected %b", in_ready, sb.size() < 4); end
      vectors++; if (out_valid !== (sb.size() != 0)) begin miscompares++; $display("FAIL b2b_out_valid: got %b expected %b", out_valid, sb.size() != 0); end
      enq = in_valid && (sb.size() < 4);
      if (sb.size() != 0) begin
        vectors++; if (out_pc !== 64'h100 + 64'(4 * n_out) || out_payload !== sb[0].payload || out_rd !== sb[0].rd) begin
          miscompares++; $display("FAIL b2b_order: got pc=%0h rd=%0d expected pc=%0h rd=%0d", out_pc, out_rd, 64'h100 + 64'(4 * n_out), sb[0].rd);
        end
        void'(sb.pop_front());
        n_out++;
      end
      if (enq) push_in();
      tick();
      if (enq) in_valid = 1'b0;
    end
    vectors++; if (n_out != 5 || sb.size() != 0) begin miscompares++; $display("FAIL b2b_drained: got %0d outputs expected 5", n_out); end
    out_ready = 1'b0;
  endtask

  task automatic test_hazard();
    in_valid = 1'b1;
    set_in(64'h300, 9'd5, 1'b1, 1'b0); push_in(); tick();
    set_in(64'h304, 9'd7, 1'b0, 1'b0); push_in(); tick();
    set_in(64'h308, 9'd0, 1'b1, 1'b0); push_in(); tick();
    in_valid = 1'b0;
    query_rs1 = 9'd5; query_rs2 = 9'd7; #1;
    vectors++; if (hazard_rs1_out !== 1'b1 || hazard_rs2_out !== 1'b0) begin miscompares++; $display("FAIL haz_5_7: got %b%b expected 10", hazard_rs1_out, hazard_rs2_out); end
    query_rs1 = 9'd0; query_rs2 = 9'd0; #1;
    vectors++; if (hazard_rs1_out !== 1'b0 || hazard_rs2_out !== 1'b0) begin miscompares++; $display("FAIL haz_r0: got %b%b expected 00", hazard_rs1_out, hazard_rs2_out); end
    // An offer that is not yet stored must not raise a hazard.
    in_valid = 1'b1; set_in(64'h30C, 9'd9, 1'b1, 1'b0);
    query_rs2 = 9'd9; #1;
    vectors++; if (hazard_rs2_out !== 1'b0) begin miscompares++; $display("FAIL haz_offer: got %b expected 0", hazard_rs2_out); end
    in_valid = 1'b0;
    query_rs1 = 9'd5;
    out_ready = 1'b1; #1;
    vectors++; if (hazard_rs1_out !== 1'b1 || out_rd !== 9'd5) begin miscompares++; $display("FAIL haz_deq_cycle: got haz=%b rd=%0d expected 1/5", hazard_rs1_out, out_rd); end
    void'(sb.pop_front());
    tick();
    out_ready = 1'b0;
    vectors++; if (hazard_rs1_out !== 1'b0) begin miscompares++; $display("FAIL haz_after_deq: got %b expected 0", hazard_rs1_out); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    set_in(64'h400, 9'd3, 1'b1, 1'b1); push_in(); tick();
    query_rs1 = 9'd3;
    set_in(64'h404, 9'd4, 1'b1, 1'b0);
    flush_in = 1'b1; #1;
    vectors++; if (count_out !== 3'd3 || out_valid !== 1'b1 || hazard_rs1_out !== 1'b1) begin
      miscompares++; $display("FAIL flush_pre: got count=%0d valid=%b haz=%b expected 3/1/1", count_out, out_valid, hazard_rs1_out);
    end
    tick();
    flush_in = 1'b0; in_valid = 1'b0;
    sb.delete();
    query_rs2 = 9'd4;
    vectors++; if (count_out !== 3'd0 || out_valid !== 1'b0 || empty_out !== 1'b1) begin
      miscompares++; $display("FAIL flush_post: got count=%0d valid=%b empty=%b expected 0/0/1", count_out, out_valid, empty_out);
    end
    vectors++; if (hazard_rs1_out !== 1'b0 || hazard_rs2_out !== 1'b0) begin miscompares++; $display("FAIL flush_hazard: got %b%b expected 00", hazard_rs1_out, hazard_rs2_out); end
    tick();
    vectors++; if (count_out !== 3'd0) begin miscompares++; $display("FAIL flush_offer_absent: got count %0d expected 0", count_out); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1; in_valid = 1'b1;
    set_in(64'h200, 9'd6, 1'b1, 1'b1);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_no_fallthrough: got %b expected 0", out_valid); end
    push_in(); tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_bp_taken !== sb[0].bp) begin
      miscompares++; $display("FAIL lat_visible: got valid=%b pc=%0h expected 1/%0h", out_valid, out_pc, sb[0].pc);
    end
    void'(sb.pop_front());
    tick();
    out_ready = 1'b0;
    vectors++; if (count_out !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_drained: got count=%0d valid=%b expected 0/0", count_out, out_valid); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    set_in(64'h500, 9'd1, 1'b1, 1'b0); push_in(); tick();
    set_in(64'h504, 9'd2, 1'b1, 1'b0); push_in(); tick();
    in_valid = 1'b0;
    vectors++; if (count_out !== 3'd2) begin miscompares++; $display("FAIL areset_pre: got count %0d expected 2", count_out); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || count_out !== 3'd0 || empty_out !== 1'b1) begin
      miscompares++; $display("FAIL areset_immediate: got valid=%b count=%0d expected 0/0", out_valid, count_out);
    end
    sb.delete();
    #1 rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    set_in(64'h600, 9'd2, 1'b1, 1'b1); push_in(); tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h600 || count_out !== 3'd1) begin
      miscompares++; $display("FAIL areset_recover: got valid=%b pc=%0h count=%0d expected 1/600/1", out_valid, out_pc, count_out);
    end
    out_ready = 1'b1; void'(sb.pop_front()); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic enq, deq;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush_in  = ($urandom_range(0, 15) == 0);
      set_in({32'h0, $urandom}, 9'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      query_rs1 = 9'($urandom_range(0, 7));
      query_rs2 = 9'($urandom_range(0, 7));
      #1;
      vectors++; if (count_out !== 3'(sb.size()) || full_out !== (sb.size() == 4) || empty_out !== (sb.size() == 0)) begin
        miscompares++; $display("FAIL rnd_count: got %0d expected %0d", count_out, sb.size());
      end
      vectors++; if (hazard_rs1_out !== exp_haz(query_rs1) || hazard_rs2_out !== exp_haz(query_rs2)) begin
        miscompares++; $display("FAIL rnd_hazard: got %b%b expected %b%b", hazard_rs1_out, hazard_rs2_out, exp_haz(query_rs1), exp_haz(query_rs2));
      end
      if (sb.size() != 0) begin
        vectors++; if (out_pc !== sb[0].pc || out_payload !== sb[0].payload || out_rd !== sb[0].rd || out_rd_write !== sb[0].rdw || out_bp_taken !== sb[0].bp) begin
          miscompares++; $display("FAIL rnd_head: got pc=%0h rd=%0d expected pc=%0h rd=%0d", out_pc, out_rd, sb[0].pc, sb[0].rd);
        end
      end
      enq = in_valid && (sb.size() < 4) && !flush_in;
      deq = out_ready && (sb.size() != 0) && !flush_in;
      if (flush_in) sb.delete();
      if (deq) void'(sb.pop_front());
      if (enq) push_in();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_latency();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
